dmem_mmio_responder: RTL and testbench

Responder on the processor's data-memory port. It serves word-addressed lw/sw requests from the M stage.
- Requests in the RAM window go to an internal synchronous RAM.
- Requests in the MMIO page go to a small register file: a MIDI-byte receive FIFO the core pops, and an audio-sample transmit FIFO the core pushes.
- Sits between the processor and the synth datapath, replacing the plain dmem block.

---
 rtl/dmem_mmio_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/dmem_mmio_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO responder: page select, register offsets, STATUS layout.
// The optional cycle counter at OFF_CYCLES is built only when MMIO_TIMER_EN is defined.
package dmem_mmio_pkg;

    localparam logic [19:0] MMIO_PAGE_DEFAULT = 20'hFFFFF;

    localparam logic [3:0] OFF_RX_DATA = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h1;
    localparam logic [3:0] OFF_TX_DATA = 4'h2;
    localparam logic [3:0] OFF_CLEAR   = 4'h3;
    localparam logic [3:0] OFF_CYCLES  = 4'h4;

    localparam int ST_RX_COUNT_LSB = 0;
    localparam int ST_TX_COUNT_LSB = 8;
    localparam int ST_RX_OVERFLOW  = 16;
    localparam int ST_TX_DROP      = 17;
    localparam int ST_TX_FULL      = 18;

    typedef enum logic {
        SRC_MMIO = 1'b0,
        SRC_RAM  = 1'b1
    } rd_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;
    logic [PW-1:0]    rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CNT_FULL);
    assign do_pop      = pop & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign rd_ptr_next = rd_ptr_reg + 1'b1;
    assign head        = head_reg;
    assign count       = count_reg;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            // Head moves only on a pop or when the first entry arrives; an emptying pop leaves it as is.
            if (do_push && empty) begin
                head_reg <= push_data;
            end else if (do_pop && do_push && count_reg == CNT_ONE) begin
                head_reg <= push_data;
            end else if (do_pop && count_reg > CNT_ONE) begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: word RAM plus an MMIO page with MIDI RX and audio TX FIFOs.
// Define MMIO_TIMER_EN to add a free-running cycle counter at MMIO offset 0x4.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int          RAM_ADDR_BITS = 12,
    parameter logic [19:0] MMIO_PAGE     = MMIO_PAGE_DEFAULT,
    parameter int          RX_DEPTH      = 16,
    parameter int          TX_DEPTH      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    input  logic        rden,
    output logic [31:0] q_dmem,
    input  logic [7:0]  midi_byte,
    input  logic        midi_valid,
    output logic [31:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready
);
    logic [31:0] ram [2**RAM_ADDR_BITS];
    logic [31:0] ram_q_reg;
    logic [31:0] mmio_q_reg;
    rd_src_e     src_reg;

    logic        ram_hit;
    logic        mmio_hit;
    logic [3:0]  offset;
    logic [RAM_ADDR_BITS-1:0] ram_idx;

    logic [7:0]                  rx_head;
    logic                        rx_full;
    logic                        rx_empty;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic                        rx_pop;
    logic                        tx_full;
    logic                        tx_empty;
    logic [$clog2(TX_DEPTH):0]   tx_count;
    logic                        tx_push;
    logic                        tx_pop;
    logic                        clear_wr;

    logic        rx_overflow_reg;
    logic        tx_drop_reg;
    logic [31:0] status_word;
    logic [31:0] mmio_rdata;

    assign ram_hit  = (address_dmem[31:RAM_ADDR_BITS] == '0);
    assign mmio_hit = (address_dmem[31:12] == MMIO_PAGE);
    assign offset   = address_dmem[3:0];
    assign ram_idx  = address_dmem[RAM_ADDR_BITS-1:0];

    assign rx_pop   = rden & mmio_hit & (offset == OFF_RX_DATA) & ~rx_empty;
    assign tx_push  = wren & mmio_hit & (offset == OFF_TX_DATA);
    assign tx_pop   = sample_valid & sample_ready;
    assign clear_wr = wren & mmio_hit & (offset == OFF_CLEAR);
    assign sample_valid = ~tx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (midi_valid),
        .push_data (midi_byte),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (data),
        .pop       (tx_pop),
        .head      (sample_out),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

`ifdef MMIO_TIMER_EN
    logic [31:0] cycles_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles_reg <= '0;
        end else if (wren && mmio_hit && offset == OFF_CYCLES) begin
            cycles_reg <= data;
        end else begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end
`endif

    always_comb begin
        status_word = '0;
        status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
        status_word[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
        status_word[ST_RX_OVERFLOW]       = rx_overflow_reg;
        status_word[ST_TX_DROP]           = tx_drop_reg;
        status_word[ST_TX_FULL]           = tx_full;
    end

    always_comb begin
        mmio_rdata = '0;
        if (mmio_hit) begin
            case (offset)
                OFF_RX_DATA: if (!rx_empty) mmio_rdata = {23'b0, 1'b1, rx_head};
                OFF_STATUS:  mmio_rdata = status_word;
`ifdef MMIO_TIMER_EN
                OFF_CYCLES:  mmio_rdata = cycles_reg;
`endif
                default:     mmio_rdata = '0;
            endcase
        end
    end

    // Enable-gated synchronous RAM; a same-address write returns the old word on the read port.
    always_ff @(posedge clock) begin
        if (wren && ram_hit) begin
            ram[ram_idx] <= data;
        end
        if (rden && ram_hit) begin
            ram_q_reg <= ram[ram_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_reg         <= SRC_MMIO;
            mmio_q_reg      <= '0;
            rx_overflow_reg <= 1'b0;
            tx_drop_reg     <= 1'b0;
        end else begin
            if (rden) begin
                src_reg    <= ram_hit ? SRC_RAM : SRC_MMIO;
                mmio_q_reg <= mmio_rdata;
            end
            // A new overflow/drop in the same cycle as a CLEAR write wins over the clear.
            if (midi_valid && rx_full && !rx_pop) begin
                rx_overflow_reg <= 1'b1;
            end else if (clear_wr && data[0]) begin
                rx_overflow_reg <= 1'b0;
            end
            if (tx_push && tx_full && !tx_pop) begin
                tx_drop_reg <= 1'b1;
            end else if (clear_wr && data[1]) begin
                tx_drop_reg <= 1'b0;
            end
        end
    end

    // Both read sources are registers, so q_dmem changes only just after a clock edge.
    assign q_dmem = (src_reg == SRC_RAM) ? ram_q_reg : mmio_q_reg;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: vector table, directed FIFO/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_dmem_mmio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [31:0] q_dmem;
    logic [7:0]  midi_byte = '0;
    logic        midi_valid = 1'b0;
    logic [31:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_RX   = 32'hFFFFF000;
    localparam logic [31:0] A_STAT = 32'hFFFFF001;
    localparam logic [31:0] A_TX   = 32'hFFFFF002;
    localparam logic [31:0] A_CLR  = 32'hFFFFF003;
    localparam logic [31:0] A_CYC  = 32'hFFFFF004;

    always #5 clock = ~clock;

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .rden         (rden),
        .q_dmem       (q_dmem),
        .midi_byte    (midi_byte),
        .midi_valid   (midi_valid),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1; address_dmem = a; data = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        rden = 1'b1; address_dmem = a;
        tick();
        rden = 1'b0;
        check(name, q_dmem, exp);
    endtask

    task automatic push_midi(input logic [7:0] b);
        midi_valid = 1'b1; midi_byte = b;
        tick();
        midi_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Reference model state
    logic [31:0] ram_m [int];
    logic [7:0]  rxq [$];
    logic [31:0] txq [$];
    logic        ovf_m;
    logic        drop_m;

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = '0;
        s[7:0]  = 8'(rxq.size());
        s[15:8] = 8'(txq.size());
        s[16]   = ovf_m;
        s[17]   = drop_m;
        s[18]   = (txq.size() == 16);
        return s;
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h00000005, 32'hCAFEBABE, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h00000005, 32'h0,        1'b1, 32'hCAFEBABE};
        vecs[2]  = '{1'b0, 1'b1, 32'h00002000, 32'h0,        1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h00000000, 32'h11111111, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h00002000, 32'hDEAD0000, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h00000000, 32'h0,        1'b1, 32'h11111111};
        vecs[6]  = '{1'b1, 1'b0, 32'h00000FFF, 32'h5A5A0001, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h00000FFF, 32'h0,        1'b1, 32'h5A5A0001};
        vecs[8]  = '{1'b0, 1'b1, 32'h00001000, 32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFFF005, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h00000005, 32'h0000BBBB, 1'b1, 32'hCAFEBABE};
        vecs[11] = '{1'b0, 1'b1, 32'h00000005, 32'h0,        1'b1, 32'h0000BBBB};
        vecs[12] = '{1'b0, 1'b0, 32'hFFFFF000, 32'h0,        1'b1, 32'h0000BBBB};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFFF001, 32'h0,        1'b1, 32'h0};

        // Reset state
        #22;
        check("rst_q", q_dmem, 32'h0);
        check("rst_valid", {31'b0, sample_valid}, 32'h0);
        check("rst_sample", sample_out, 32'h0);
        reset = 1'b0;
        tick();

        // Table-driven RAM / decode vectors
        for (int i = 0; i < 14; i++) begin
            wren = vecs[i].wr; rden = vecs[i].rd;
            address_dmem = vecs[i].addr; data = vecs[i].wdata;
            tick();
            wren = 1'b0; rden = 1'b0;
            if (vecs[i].chk) check($sformatf("vec%0d", i), q_dmem, vecs[i].exp);
        end

        // RX FIFO basic pops
        push_midi(8'h90); push_midi(8'h3C); push_midi(8'h7F);
        do_read("rx0", A_RX, 32'h190);
        do_read("rx1", A_RX, 32'h13C);
        do_read("rx2", A_RX, 32'h17F);
        do_read("rx_empty", A_RX, 32'h0);
        do_read("rx_stat0", A_STAT, 32'h0);

        // Empty FIFO with push and pop together: no bypass
        midi_valid = 1'b1; midi_byte = 8'hAB; rden = 1'b1; address_dmem = A_RX;
        tick();
        midi_valid = 1'b0; rden = 1'b0;
        check("rx_nobypass", q_dmem, 32'h0);
        do_read("rx_stat1", A_STAT, 32'h1);
        do_read("rx_ab", A_RX, 32'h1AB);

        // RX_DATA address held with rden low: no pops
        push_midi(8'h11); push_midi(8'h22);
        address_dmem = A_RX;
        for (int i = 0; i < 10; i++) tick();
        do_read("rx_hold_stat", A_STAT, 32'h2);
        do_read("rx_h0", A_RX, 32'h111);
        do_read("rx_h1", A_RX, 32'h122);

        // RX overflow
        for (int i = 0; i < 17; i++) push_midi(8'h40 + 8'(i));
        do_read("rx_ovf_stat", A_STAT, 32'h00010010);
        do_write(A_CLR, 32'h1);
        do_read("rx_clr_stat", A_STAT, 32'h00000010);
        for (int i = 0; i < 16; i++) do_read($sformatf("rx_ovf%0d", i), A_RX, 32'h100 | (32'h40 + i));
        do_read("rx_lost", A_RX, 32'h0);

        // TX fill with consumer stalled, then drain
        sample_ready = 1'b0;
        for (int i = 0; i < 17; i++) do_write(A_TX, 32'h100 + i);
        do_read("tx_full_stat", A_STAT, 32'h00061000);
        check("tx_head", sample_out, 32'h100);
        do_write(A_CLR, 32'h2);
        do_read("tx_clr_stat", A_STAT, 32'h00041000);
        sample_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_v%0d", i), {31'b0, sample_valid}, 32'h1);
            check($sformatf("tx_d%0d", i), sample_out, 32'h100 + i);
            tick();
        end
        check("tx_drained", {31'b0, sample_valid}, 32'h0);
        sample_ready = 1'b0;

        // Reset mid-stream
        for (int i = 0; i < 5; i++) push_midi(8'h50 + 8'(i));
        for (int i = 0; i < 5; i++) do_write(A_TX, 32'hA0 + i);
        do_read("pre_rst_q", 32'h5, 32'h0000BBBB);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, sample_valid}, 32'h0);
        check("mid_rst_q", q_dmem, 32'h0);
        tick();
        reset = 1'b0;
        do_read("post_rst_stat", A_STAT, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        rden = 1'b1; address_dmem = A_CYC;
        tick();
        rden = 1'b0;
`ifdef MMIO_TIMER_EN
        check("timer_near10", {31'b0, (q_dmem >= 32'd8 && q_dmem <= 32'd11)}, 32'h1);
`else
        check("cycles_unmapped", q_dmem, 32'h0);
`endif

        // Randomized traffic against the queue model
        ovf_m = 1'b0; drop_m = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int op;
            int a;
            logic [31:0] exp_q;
            logic rx_pop_m;
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 63);
            wren = 1'b0; rden = 1'b0; data = $urandom; address_dmem = '0;
            midi_valid = ($urandom_range(0, 1) == 0);
            midi_byte  = 8'($urandom);
            sample_ready = ((n / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (op == 1 && !ram_m.exists(a)) op = 0;
            case (op)
                0: begin wren = 1'b1; address_dmem = 32'(a); end
                1: begin rden = 1'b1; address_dmem = 32'(a); end
                2, 3: begin rden = 1'b1; address_dmem = A_RX; end
                4: begin rden = 1'b1; address_dmem = A_STAT; end
                5: begin wren = 1'b1; address_dmem = A_TX; end
                6: begin wren = 1'b1; address_dmem = A_CLR; data = 32'($urandom_range(0, 3)); end
                default: begin rden = 1'b1; address_dmem = 32'h00010000 + 32'($urandom_range(0, 255)); end
            endcase

            exp_q = 32'h0;
            if (op == 1) exp_q = ram_m[a];
            else if (op == 2 || op == 3) exp_q = (rxq.size() > 0) ? {23'b0, 1'b1, rxq[0]} : 32'h0;
            else if (op == 4) exp_q = status_m();

            rx_pop_m = (op == 2 || op == 3) && rxq.size() > 0;
            if (op == 0) ram_m[a] = data;
            if (op == 6) begin
                if (data[0]) ovf_m = 1'b0;
                if (data[1]) drop_m = 1'b0;
            end
            if (rx_pop_m) void'(rxq.pop_front());
            if (midi_valid) begin
                if (rxq.size() < 16) rxq.push_back(midi_byte);
                else ovf_m = 1'b1;
            end
            if (sample_ready && txq.size() > 0) void'(txq.pop_front());
            if (op == 5) begin
                if (txq.size() < 16) txq.push_back(data);
                else drop_m = 1'b1;
            end

            tick();
            if (rden) check($sformatf("rnd%0d_q", n), q_dmem, exp_q);
            check($sformatf("rnd%0d_valid", n), {31'b0, sample_valid}, {31'b0, txq.size() > 0});
            if (txq.size() > 0) check($sformatf("rnd%0d_sample", n), sample_out, txq[0]);
        end
        wren = 1'b0; rden = 1'b0; midi_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
